// File: rtl/lotr_pkg.sv
// Shared types for the data-memory fabric port: opcode encoding, response entry, memory geometry.
package lotr_pkg;

  localparam int unsigned MSB_D_MEM        = 11;
  // Response entries carry the widest tag any fabric port may use; ports zero-extend.
  localparam int unsigned FABRIC_TAG_W_MAX = 8;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } t_fabric_opcode;

  typedef struct packed {
    logic [31:0]                 data;
    logic [FABRIC_TAG_W_MAX-1:0] tag;
    logic                        is_wr;
  } t_d_mem_fabric_rsp;

endpackage

// File: rtl/d_mem_rsp_fifo.sv
// Synchronous response FIFO with async active-low reset; DEPTH must be a power of 2, >= 2.
module d_mem_rsp_fifo
  import lotr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  t_d_mem_fabric_rsp i_push_data,
  input  logic              i_pop,
  output t_d_mem_fabric_rsp o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  t_d_mem_fabric_rsp r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && o_full));

endmodule

// File: rtl/d_mem_fabric_port.sv
// Fabric front end for data-memory port B: registered request stage, 2-cycle read return,
// credit-protected tagged response FIFO. Define D_MEM_FABRIC_WR_ACK_EN to acknowledge writes.
module d_mem_fabric_port
  import lotr_pkg::*;
#(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_opcode,
  input  logic [31:0]          req_address,
  input  logic [31:0]          req_data,
  input  logic [3:0]           req_byteena,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 rsp_is_wr,
  output logic [MSB_D_MEM-2:0] address_b,
  output logic [3:0]           byteena_b,
  output logic [31:0]          data_b,
  output logic                 rden_b,
  output logic                 wren_b,
  input  logic [31:0]          q_b,
  output logic                 misalign_err
);

  localparam int unsigned CRD_W = $clog2(RSP_DEPTH + 1);

  logic [CRD_W-1:0]     r_credits;
  logic                 r_rden;
  logic                 r_wren;
  logic [MSB_D_MEM-2:0] r_address;
  logic [3:0]           r_byteena;
  logic [31:0]          r_data;
  logic                 r_s1_vld;
  logic                 r_s1_is_wr;
  logic [TAG_W-1:0]     r_s1_tag;
  logic                 r_s2_vld;
  logic                 r_s2_is_wr;
  logic [TAG_W-1:0]     r_s2_tag;
  logic                 r_misalign;

  logic                 w_accept;
  logic                 w_needs_rsp;
  logic                 w_rsp_pop;
  logic                 w_empty;
  logic                 w_full;
  logic [CRD_W-1:0]     w_count;
  t_d_mem_fabric_rsp    w_push_data;
  t_d_mem_fabric_rsp    w_head;
  logic                 w_unused;

  assign req_ready = (r_credits != '0);
  assign w_accept  = req_valid && req_ready;
  assign w_rsp_pop = rsp_valid && rsp_ready;

`ifdef D_MEM_FABRIC_WR_ACK_EN
  assign w_needs_rsp = 1'b1;
`else
  assign w_needs_rsp = (t_fabric_opcode'(req_opcode) == RD);
`endif

  // Credits cover every slot a response can occupy (S1, S2, FIFO), so the FIFO never overflows.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= CRD_W'(RSP_DEPTH);
    end else begin
      case ({w_accept && w_needs_rsp, w_rsp_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rden     <= 1'b0;
      r_wren     <= 1'b0;
      r_address  <= '0;
      r_byteena  <= '0;
      r_data     <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_is_wr <= 1'b0;
      r_s1_tag   <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_is_wr <= 1'b0;
      r_s2_tag   <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_rden     <= w_accept && (t_fabric_opcode'(req_opcode) == RD);
      r_wren     <= w_accept && (t_fabric_opcode'(req_opcode) == WR);
      if (w_accept) begin
        r_address <= req_address[MSB_D_MEM:2];
        r_byteena <= req_byteena;
        r_data    <= req_data;
      end
      r_s1_vld   <= w_accept && w_needs_rsp;
      r_s1_is_wr <= req_opcode;
      r_s1_tag   <= req_tag;
      r_s2_vld   <= r_s1_vld;
      r_s2_is_wr <= r_s1_is_wr;
      r_s2_tag   <= r_s1_tag;
      if (w_accept && (req_address[1:0] != 2'b00)) r_misalign <= 1'b1;
    end
  end

  always_comb begin
    w_push_data       = '0;
    w_push_data.tag   = FABRIC_TAG_W_MAX'(r_s2_tag);
    w_push_data.is_wr = r_s2_is_wr;
    w_push_data.data  = r_s2_is_wr ? 32'h0 : q_b;
  end

  d_mem_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .CNT_W (CRD_W)
  ) u_rsp_fifo (
    .i_clk       (clock),
    .i_rst_n     (rst_n),
    .i_push      (r_s2_vld),
    .i_push_data (w_push_data),
    .i_pop       (w_rsp_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign rden_b       = r_rden;
  assign wren_b       = r_wren;
  assign address_b    = r_address;
  assign byteena_b    = r_byteena;
  assign data_b       = r_data;
  assign misalign_err = r_misalign;

  // Head entry is gated so an empty FIFO presents zeros rather than stale storage.
  assign rsp_valid = !w_empty;
  assign rsp_data  = rsp_valid ? w_head.data : 32'h0;
  assign rsp_tag   = rsp_valid ? w_head.tag[TAG_W-1:0] : '0;
`ifdef D_MEM_FABRIC_WR_ACK_EN
  assign rsp_is_wr = rsp_valid && w_head.is_wr;
`else
  assign rsp_is_wr = 1'b0;
`endif

  assign w_unused = ^{req_address[31:MSB_D_MEM+1], w_head.tag, w_head.is_wr, w_full, w_count};

endmodule

// File: doc/d_mem_fabric_port.md
Name: d_mem_fabric_port

Overview:
- Fabric-side front end for port B of the dual-port data memory.
- Accepts fabric read/write requests over a valid/ready handshake and drives the memory's port B signals (address_b, byteena_b, data_b, rden_b, wren_b) one request per cycle from registers.
- Captures q_b, which arrives two cycles after acceptance.
- Returns tagged read responses through a credit-protected response FIFO, so the fabric may stall rsp_ready without ever losing data.

Parameters:
- TAG_W, 4, width of the request/response tag.
- RSP_DEPTH, 4, response FIFO entries; must be a power of 2 and at least 2.

Ports:
- clock  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fabric request valid.
- req_ready  out  1  block can accept a request this cycle.
- req_opcode  in  1  0 = read, 1 = write.
- req_address  in  32  byte address; bits [MSB_D_MEM:2] select the word, bits above are ignored.
- req_data  in  32  write data.
- req_byteena  in  4  write byte enables.
- req_tag  in  TAG_W  request tag, echoed on the response.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  fabric accepts the response.
- rsp_data  out  32  read data.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_is_wr  out  1  response is a write acknowledge.
- address_b  out  MSB_D_MEM-1  word address to memory port B.
- byteena_b  out  4  to memory.
- data_b  out  32  to memory.
- rden_b  out  1  to memory.
- wren_b  out  1  to memory.
- q_b  in  32  registered read data from memory.
- misalign_err  out  1  sticky flag: a request arrived with req_address[1:0] != 0.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- Reset: all outputs 0, FIFO empty, pipeline empty, credits = RSP_DEPTH, misalign_err = 0.
- Handshake: a request is accepted on a clock edge where req_valid && req_ready. req_ready is combinational from registered state only (credit counter), never from req_valid.
- Stage S1 (cycle after acceptance): registered rden_b/wren_b/address_b/byteena_b/data_b are driven for exactly one cycle; rden_b = !opcode, wren_b = opcode. With no accept, rden_b = wren_b = 0 and address/data hold their last value.
- Stage S2: q_b is valid in the cycle after S1. The tag and opcode travel through S1/S2 in a 2-deep shift register. A read entry is pushed into the FIFO at the end of S2.
- Latency: an accept at edge T gives rsp_valid at the earliest in the cycle after edge T+2 (3 cycles accept-to-response when the FIFO is empty).
- Throughput: one request per cycle sustained while credits are available.
- Credits:
  - Decremented on accept of any request that produces a response.
  - Incremented on rsp_valid && rsp_ready.
  - Both in the same cycle: net 0.
  - req_ready = (credits != 0). Credits cover S1 + S2 + FIFO, so a push never finds the FIFO full; a full-FIFO push is an assertion failure.
- FIFO:
  - rsp_* are driven from the head entry; rsp_valid = !empty.
  - Push and pop in the same cycle on a non-empty FIFO keep the count unchanged.
  - Pointers wrap modulo RSP_DEPTH; the count is RSP_DEPTH+1 states wide.
- Writes (macro off): posted, consume no credit, produce no response.
- Ordering: responses return in acceptance order. A read accepted the cycle after a write to the same word returns the new data.
- misalign_err: set on any accepted request with req_address[1:0] != 0; the request still executes on the word (low bits dropped). Cleared only by reset.
- Reset mid-operation: in-flight S1/S2 entries and FIFO contents are discarded; rden_b/wren_b drop to 0 asynchronously.

Optional Feature:
- Macro: D_MEM_FABRIC_WR_ACK_EN.
- Defined: writes consume a credit, flow through S1/S2, and push a FIFO entry with rsp_is_wr = 1, rsp_data = 0, tag echoed.
- Undefined: writes are posted as above and rsp_is_wr is tied to 0.

Decomposition:
- Shared package (lotr_pkg) holds:
  - t_fabric_opcode enum: RD = 1'b0, WR = 1'b1.
  - t_d_mem_fabric_rsp struct: data, tag, is_wr.
  - MSB_D_MEM, already present.
- One sub-module, d_mem_rsp_fifo: a parameterised synchronous FIFO with async active-low reset and a push/pop/full/empty/count interface, holding t_d_mem_fabric_rsp.

Test Plan:
- Write 0xDEADBEEF, byteena 4'hF, to byte address 0x40 (tag 1), then read 0x40 (tag 2) -> rsp_data = 0xDEADBEEF, tag 2, 3 cycles after the read accept.
- Write 0x000000AA with byteena 4'b0001 over a word holding 0x11223344 at 0x80, then read it -> 0x112233AA.
- 8 back-to-back reads with rsp_ready = 0 -> req_ready drops after 4 accepts (RSP_DEPTH = 4). Raise rsp_ready -> all 8 responses return in order, tags 0..7, with no drop or duplicate.
- Request to byte address 0x43 -> misalign_err = 1 and stays 1; the access hits the word at 0x40.
- Assert rst_n low 1 cycle after a read accept -> no response appears, credits return to 4, rden_b = 0 immediately.
- With D_MEM_FABRIC_WR_ACK_EN: a write with tag 5 -> response rsp_is_wr = 1, tag 5, rsp_data = 0. Without the macro: no response and credits unchanged.
